key_pulse_gen: RTL and testbench
================================

# key_pulse_gen

Parametrised pushbutton conditioning block for the lab top levels. It takes N raw active-low KEY inputs, synchronises and debounces each one, and produces a clean level plus single-cycle press and release pulses. An optional per-channel auto-repeat emits press pulses while a key is held. It replaces direct use of raw KEY bits as clock or step strobes in the CPU datapath tops.

## Interface
- N_KEYS, 4, number of independent key channels
- DB_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (>=1)
- RPT_DELAY, 64, cycles from accepted press to first auto-repeat pulse (>=1)
- RPT_PERIOD, 16, cycles between subsequent auto-repeat pulses (>=1)

- clk  input  1  single system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- key_n  input  N_KEYS  raw pushbuttons, 0 = pressed, asynchronous to clk
- rpt_en  input  N_KEYS  per-channel auto-repeat enable, synchronous to clk
- level  output  N_KEYS  debounced state, 1 = pressed
- press  output  N_KEYS  one-cycle pulse on accepted press and on each repeat
- release  output  N_KEYS  one-cycle pulse on accepted release

## Operation
- Channels are fully independent. Each channel has:
  - a 2-flop synchroniser
  - a debounce counter of width $clog2(DB_CYCLES+1)
  - a repeat counter of width $clog2(max(RPT_DELAY,RPT_PERIOD)+1)
  - a 3-state FSM
- Reset (async assert, sync-safe deassert by design):
  - synchroniser flops = 1 (released)
  - level = 0, press = 0, release = 0
  - all counters = 0, FSM = IDLE
- Debounce:
  - Each cycle where the synchronised sample differs from level, the debounce counter increments.
  - Any cycle where they match clears the counter.
  - When the counter would reach DB_CYCLES, level toggles and the counter clears.
  - Mismatch runs shorter than DB_CYCLES have no effect.
- FSM states:
  - IDLE: level = 0.
  - HELD: level = 1, repeat counter counting toward RPT_DELAY.
  - REPEAT: level = 1, repeat counter counting toward RPT_PERIOD.
- FSM transitions:
  - IDLE -> HELD on accepted press; press = 1 for that cycle; repeat counter cleared.
  - HELD with rpt_en = 1: the counter increments each cycle. At RPT_DELAY: press pulse, counter cleared, go to REPEAT.
  - REPEAT with rpt_en = 1: press pulse every RPT_PERIOD cycles.
  - rpt_en = 0 in HELD or REPEAT: counter cleared, go to HELD, no pulses. When rpt_en is re-asserted, the delay restarts from 0.
  - HELD/REPEAT -> IDLE on accepted release; release = 1 for that cycle; counter cleared.
- A key held low through reset deassertion counts as a press.

## Timing
- press, release and level are registered outputs; there is no combinational path from any input to any output.
- Press latency: if key_n goes low before edge 1 and stays low, level and press are first high after edge DB_CYCLES+2.
- Release latency: same, symmetric (release and level change after edge DB_CYCLES+2).
- press and release are each exactly one cycle wide and never both high on one channel.
- Auto-repeat timing: first press at cycle T, then repeats at T+RPT_DELAY, then every +RPT_PERIOD.
- Repeat due in the same cycle a release is accepted: release wins; no press that cycle.
- Reset mid-operation: outputs clear immediately, without waiting for clk. Pending counts are discarded and no release pulse is generated.
- rpt_en sampled directly (already synchronous); a change takes effect on the next edge.

## Test plan
All scenarios use DB_CYCLES=4, RPT_DELAY=8, RPT_PERIOD=3, N_KEYS=4.
- Reset with key_n[0]=0 held:
  - During reset, level/press/release = 0 asynchronously.
  - After reset_n rises, press[0] is high for one cycle and level[0] rises after edge 6.
- Bounce on key_n[1]:
  - Pattern low 3 cycles, high 1, low 2, then steady low.
  - Required: exactly one press[1] pulse, 6 edges after the steady low begins; level never toggles before that.
- Clean press/release, rpt_en=0:
  - Hold key_n[2] low for 20 cycles, then release.
  - Required: one press pulse, level high for 20 cycles, one release pulse 6 edges after release, no repeat pulses.
- Auto-repeat on channel 3:
  - rpt_en[3]=1, hold 30 cycles.
  - Required: press pulses at T, T+8, T+11, T+14, ... continuing while held.
  - Deassert rpt_en mid-hold: pulses stop. Re-assert: next pulse 8 cycles later.
- Simultaneous events:
  - Time a release to be accepted on the same edge a repeat is due. Required: release only, no press.
  - Press two channels on the same cycle. Required: identical independent pulse timing.
- Reset mid-repeat:
  - Assert reset_n=0 while in REPEAT. Required: outputs 0 immediately.
  - Keep the key held through reset release. Required: a fresh press after edge 6, with the full delay before the first repeat.

Source files
------------

// File: rtl/key_pulse_gen.sv
// rtl/key_pulse_gen.sv - per-key synchroniser, debouncer and press/release/auto-repeat pulse generator
module key_pulse_gen #(
  parameter int N_KEYS     = 4,
  parameter int DB_CYCLES  = 16,
  parameter int RPT_DELAY  = 64,
  parameter int RPT_PERIOD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [N_KEYS-1:0] rpt_en,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] release_pulse
);

  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic             sync_meta;
    logic             sync_key;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [1:0]       state;
    logic             level_r;
    logic             press_r;
    logic             release_r;
    logic             mismatch;
    logic             accept;
    logic             rpt_due;

    // The synchronised sample is still active-low; level is active-high.
    always_comb begin
      mismatch = (~sync_key) != level_r;
      accept   = mismatch && (db_cnt == DB_LAST);
      rpt_due  = rpt_en[i] &&
                 (((state == ST_HELD)   && (rpt_cnt == DELAY_LAST)) ||
                  ((state == ST_REPEAT) && (rpt_cnt == PERIOD_LAST)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_meta <= 1'b1;
        sync_key  <= 1'b1;
        db_cnt    <= '0;
        rpt_cnt   <= '0;
        state     <= ST_IDLE;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        sync_meta <= key_n[i];
        sync_key  <= sync_meta;
        press_r   <= 1'b0;
        release_r <= 1'b0;

        if (accept) begin
          db_cnt  <= '0;
          level_r <= ~level_r;
        end else if (mismatch) begin
          db_cnt <= db_cnt + 1'b1;
        end else begin
          db_cnt <= '0;
        end

        // An accepted release pre-empts any repeat that falls due on the same edge.
        case (state)
          ST_IDLE: begin
            rpt_cnt <= '0;
            if (accept) begin
              state   <= ST_HELD;
              press_r <= 1'b1;
            end
          end
          ST_HELD, ST_REPEAT: begin
            if (accept) begin
              state     <= ST_IDLE;
              rpt_cnt   <= '0;
              release_r <= 1'b1;
            end else if (!rpt_en[i]) begin
              state   <= ST_HELD;
              rpt_cnt <= '0;
            end else if (rpt_due) begin
              state   <= ST_REPEAT;
              rpt_cnt <= '0;
              press_r <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            rpt_cnt <= '0;
          end
        endcase
      end
    end

    assign level[i]         = level_r;
    assign press[i]         = press_r;
    assign release_pulse[i] = release_r;
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb/tb_key_pulse_gen.sv - randomized and directed bench for key_pulse_gen against a timestamp-based reference model
module tb_key_pulse_gen;

  localparam int N   = 4;
  localparam int DB  = 4;
  localparam int DLY = 8;
  localparam int PER = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] rpt_en = '0;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;

  key_pulse_gen #(
    .N_KEYS(N), .DB_CYCLES(DB), .RPT_DELAY(DLY), .RPT_PERIOD(PER)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .rpt_en(rpt_en),
    .level(level), .press(press), .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail = 0;
  int           n;
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level, m_press, m_rel;
  int           run[N];
  int           anchor[N];
  bit           first[N];
  int           press_cnt[N], rel_cnt[N], last_press[N], last_rel[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; last_press[c] = -1; last_rel[c] = -1;
    end
  endtask

  task automatic model_reset();
    n = 0;
    hist.delete();
    m_level = '0; m_press = '0; m_rel = '0;
    for (int c = 0; c < N; c++) begin
      run[c] = 0; anchor[c] = 0; first[c] = 1'b1;
    end
  endtask

  // Edge n sees the key as it was two edges earlier; a change is accepted after DB
  // consecutive disagreeing samples. Repeats are timed from the last press or rpt_en-low edge.
  task automatic model_edge();
    logic samp;
    bit   acc;
    n++;
    hist.push_back(key_n);
    for (int c = 0; c < N; c++) begin
      samp = (n >= 3) ? hist[n-3][c] : 1'b1;
      m_press[c] = 1'b0; m_rel[c] = 1'b0; acc = 1'b0;
      if ((!samp) != m_level[c]) begin
        run[c]++;
        if (run[c] == DB) begin
          acc = 1'b1; run[c] = 0; m_level[c] = !m_level[c];
          if (m_level[c]) begin
            m_press[c] = 1'b1; anchor[c] = n; first[c] = 1'b1;
          end else begin
            m_rel[c] = 1'b1;
          end
        end
      end else begin
        run[c] = 0;
      end
      if (m_level[c] && !acc) begin
        if (!rpt_en[c]) begin
          anchor[c] = n; first[c] = 1'b1;
        end else if (n - anchor[c] == (first[c] ? DLY : PER)) begin
          m_press[c] = 1'b1; anchor[c] = n; first[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("level", 32'(level), 32'(m_level));
    chk("press", 32'(press), 32'(m_press));
    chk("release", 32'(release_pulse), 32'(m_rel));
    for (int c = 0; c < N; c++) begin
      if (press[c]) begin press_cnt[c]++; last_press[c] = n; end
      if (release_pulse[c]) begin rel_cnt[c]++; last_rel[c] = n; end
    end
  endtask

  // Called at a falling edge; asserts reset mid-cycle and releases it on a later falling edge.
  task automatic do_reset_async();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_level", 32'(level), 0);
    chk("rst_async_press", 32'(press), 0);
    chk("rst_async_release", 32'(release_pulse), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_held_level", 32'(level), 0);
    chk("rst_held_press", 32'(press), 0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int L, R, E, rate, idx;

    // Reset with key 0 held down
    key_n = 4'b1110;
    model_reset();
    clear_stats();
    do_reset_async();
    repeat (10) tick();
    chk("s1_press_edge", last_press[0], 6);
    chk("s1_press_cnt", press_cnt[0], 1);
    key_n[0] = 1'b1;
    repeat (8) tick();

    // Bounce on key 1: low 3, high 1, then uninterrupted low
    clear_stats();
    key_n[1] = 1'b0;
    repeat (3) tick();
    key_n[1] = 1'b1;
    tick();
    key_n[1] = 1'b0;
    L = n + 1;
    repeat (12) tick();
    chk("s2_press_cnt", press_cnt[1], 1);
    chk("s2_press_edge", last_press[1], L + 5);
    key_n[1] = 1'b1;
    repeat (8) tick();

    // Clean press and release on key 2, no repeat
    clear_stats();
    key_n[2] = 1'b0;
    L = n + 1;
    repeat (20) tick();
    key_n[2] = 1'b1;
    R = n + 1;
    repeat (10) tick();
    chk("s3_press_cnt", press_cnt[2], 1);
    chk("s3_press_edge", last_press[2], L + 5);
    chk("s3_rel_cnt", rel_cnt[2], 1);
    chk("s3_rel_edge", last_rel[2], R + 5);

    // Auto-repeat on key 3, pause and resume, release colliding with a due repeat
    clear_stats();
    rpt_en[3] = 1'b1;
    key_n[3] = 1'b0;
    L = n + 1;
    repeat (30) tick();
    chk("s4_rpt_cnt", press_cnt[3], 7);
    chk("s4_rpt_last", last_press[3], L + 28);
    rpt_en[3] = 1'b0;
    repeat (5) tick();
    chk("s4_paused_cnt", press_cnt[3], 7);
    rpt_en[3] = 1'b1;
    E = n + 1;
    repeat (7) tick();
    chk("s4_resume_quiet", press_cnt[3], 7);
    tick();
    chk("s4_resume_edge", last_press[3], E + 7);
    key_n[3] = 1'b1;
    repeat (8) tick();
    chk("s4_rel_edge", last_rel[3], E + 13);
    chk("s4_no_press_on_rel", last_press[3], E + 10);
    chk("s4_total_press", press_cnt[3], 9);
    rpt_en[3] = 1'b0;
    repeat (4) tick();

    // Two keys pressed on the same cycle
    clear_stats();
    key_n[1:0] = 2'b00;
    L = n + 1;
    repeat (10) tick();
    chk("s5_press0_edge", last_press[0], L + 5);
    chk("s5_press1_edge", last_press[1], L + 5);
    key_n[1:0] = 2'b11;
    R = n + 1;
    repeat (10) tick();
    chk("s5_rel0_edge", last_rel[0], R + 5);
    chk("s5_rel1_edge", last_rel[1], R + 5);

    // Reset while repeating, key kept held through reset
    rpt_en[3] = 1'b1;
    key_n[3] = 1'b0;
    repeat (18) tick();
    do_reset_async();
    clear_stats();
    repeat (16) tick();
    chk("s6_press_cnt", press_cnt[3], 2);
    chk("s6_first_rpt_edge", last_press[3], 14);
    chk("s6_no_release", rel_cnt[3], 0);
    key_n[3] = 1'b1;
    rpt_en[3] = 1'b0;
    repeat (10) tick();

    // Randomized traffic with varying bounce density
    rate = 8;
    for (int t = 0; t < 1500; t++) begin
      if (t % 100 == 0) begin
        idx = $urandom_range(0, 2);
        rate = (idx == 0) ? 2 : (idx == 1) ? 8 : 40;
      end
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, rate - 1) == 0) key_n[c] = ~key_n[c];
      if ($urandom_range(0, 30) == 0) begin
        idx = $urandom_range(0, N - 1);
        rpt_en[idx] = ~rpt_en[idx];
      end
      if ($urandom_range(0, 700) == 0) do_reset_async();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
